// File: rtl/debounce_pulse.sv
// ---------------------------------------------------------------------------
// debounce_pulse
//
// Turns a raw, bouncy push-button level into clean single-cycle strobes that
// can drive a counter enable directly. The raw input is synchronised, both
// edges are debounced, and an optional auto-repeat keeps emitting strobes
// while the button stays held.
//
// Parameters
//   SYNC_STAGES   synchroniser depth (>= 2)
//   DB_CYCLES     identical synchronised samples needed to accept a change
//   REPEAT_EN     1 = auto-repeat while held, 0 = one strobe per press
//   REPEAT_DELAY  edges from the initial strobe to the first repeat strobe
//   REPEAT_PERIOD edges between successive repeat strobes
//
// Ports
//   clk     single clock, all flops on its rising edge
//   rst     asynchronous active-high reset, clears every flop
//   btn_in  raw asynchronous button level, 1 = pressed
//   pulse   registered one-cycle strobe
//   level   registered debounced button level
//   held    registered, high while in the auto-repeat phase
// ---------------------------------------------------------------------------
module debounce_pulse #(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse,
    output logic level,
    output logic held
);

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_SAT      = DB_W'(DB_CYCLES);
    localparam logic [REP_W-1:0] REP_SAT     = REP_W'(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_PRESS_CHK   = 3'd1;
    localparam logic [2:0] ST_PRESSED     = 3'd2;
    localparam logic [2:0] ST_REPEAT      = 3'd3;
    localparam logic [2:0] ST_RELEASE_CHK = 3'd4;

    logic [SYNC_STAGES-1:0] r_syncChain;
    logic [2:0]             r_state;
    logic [DB_W-1:0]        r_dbCnt;
    logic [REP_W-1:0]       r_repCnt;
    logic                   r_pulse;
    logic                   r_level;
    logic                   r_held;

    logic                   w_btnSync;
    logic [2:0]             w_stateNext;
    logic [DB_W-1:0]        w_dbNext;
    logic [REP_W-1:0]       w_repNext;
    logic                   w_pulseNext;
    logic                   w_levelNext;
    logic                   w_heldNext;
    logic                   w_repHit;
    logic [2:0]             w_pressTarget;
    logic [DB_W-1:0]        w_dbInc;
    logic [REP_W-1:0]       w_repInc;

    assign w_btnSync = r_syncChain[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain; only the last
    // stage is ever looked at by the rest of the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Next-state logic. rep_cnt only advances on edges where the button is
    // seen pressed while the debounced level is high, so every edge spent
    // with a low sample (a release excursion) pushes later repeat strobes
    // out by exactly one edge. The edge that returns from RELEASE_CHK counts
    // like any other pressed edge and may itself carry a repeat strobe.
    always_comb begin
        w_stateNext   = r_state;
        w_dbNext      = r_dbCnt;
        w_repNext     = r_repCnt;
        w_pulseNext   = 1'b0;
        w_levelNext   = r_level;
        w_heldNext    = r_held;
        w_repHit      = r_held ? (r_repCnt >= PERIOD_LAST) : (r_repCnt >= DELAY_LAST);
        w_pressTarget = r_held ? ST_REPEAT : ST_PRESSED;
        w_dbInc       = (r_dbCnt == DB_SAT) ? r_dbCnt : r_dbCnt + 1'b1;
        w_repInc      = (r_repCnt == REP_SAT) ? r_repCnt : r_repCnt + 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_btnSync) begin
                    if (DB_CYCLES == 1) begin
                        w_stateNext = ST_PRESSED;
                        w_levelNext = 1'b1;
                        w_pulseNext = 1'b1;
                        w_dbNext    = '0;
                        w_repNext   = '0;
                    end else begin
                        w_stateNext = ST_PRESS_CHK;
                        w_dbNext    = DB_ONE;
                    end
                end
            end

            ST_PRESS_CHK: begin
                if (!w_btnSync) begin
                    w_stateNext = ST_IDLE;
                    w_dbNext    = '0;
                end else if (r_dbCnt >= DB_LAST) begin
                    w_stateNext = ST_PRESSED;
                    w_levelNext = 1'b1;
                    w_pulseNext = 1'b1;
                    w_dbNext    = '0;
                    w_repNext   = '0;
                end else begin
                    w_dbNext = w_dbInc;
                end
            end

            ST_PRESSED, ST_REPEAT, ST_RELEASE_CHK: begin
                if (w_btnSync) begin
                    w_dbNext = '0;
                    if ((REPEAT_EN != 0) && w_repHit) begin
                        w_stateNext = ST_REPEAT;
                        w_heldNext  = 1'b1;
                        w_pulseNext = 1'b1;
                        w_repNext   = '0;
                    end else begin
                        w_stateNext = w_pressTarget;
                        w_repNext   = w_repInc;
                    end
                end else if ((r_state != ST_RELEASE_CHK) && (DB_CYCLES != 1)) begin
                    w_stateNext = ST_RELEASE_CHK;
                    w_dbNext    = DB_ONE;
                end else if ((r_state != ST_RELEASE_CHK) || (r_dbCnt >= DB_LAST)) begin
                    w_stateNext = ST_IDLE;
                    w_levelNext = 1'b0;
                    w_heldNext  = 1'b0;
                    w_dbNext    = '0;
                    w_repNext   = '0;
                end else begin
                    w_dbNext = w_dbInc;
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
                w_levelNext = 1'b0;
                w_heldNext  = 1'b0;
                w_dbNext    = '0;
                w_repNext   = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_dbCnt  <= '0;
            r_repCnt <= '0;
            r_pulse  <= 1'b0;
            r_level  <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_dbCnt  <= w_dbNext;
            r_repCnt <= w_repNext;
            r_pulse  <= w_pulseNext;
            r_level  <= w_levelNext;
            r_held   <= w_heldNext;
        end
    end

    assign pulse = r_pulse;
    assign level = r_level;
    assign held  = r_held;

endmodule
